fifo_sync_ctrl: RTL

//  Single-clock FIFO controller that sequences the dual-port FIFO memory (sync write, async read).

---
 rtl/fifo_defs.sv | 14 +
 rtl/fifo_ptr.sv | 22 ++
 rtl/fifo_sync_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/fifo_defs.sv
// Shared sizing helpers for the same-clock FIFO controller and its pointer counters.
package fifo_defs;

    // Number of memory entries addressed by an ADDRSIZE-bit address.
    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    // Pointers carry one extra wrap bit above the address so full and empty differ.
    function automatic int unsigned fifo_ptr_width(input int unsigned addrsize);
        return addrsize + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Binary wrap counter used as a FIFO read or write pointer; flush reloads it to zero.
module fifo_ptr #(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    output logic [PW-1:0] ptr
);

    // Wraps modulo 2^PW on its own; the top bit toggles once per pass through the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (flush)
            ptr <= '0;
        else if (en)
            ptr <= ptr + PW'(1);
    end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FWFT FIFO controller: owns the pointers, drives the dual-port memory
// addresses/write enable, and decodes occupancy status from the registered pointers.
module fifo_sync_ctrl
    import fifo_defs::*;
#(
    parameter int ADDRSIZE      = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                mem_wclken,
    output logic [ADDRSIZE-1:0] mem_waddr,
    output logic [ADDRSIZE-1:0] mem_raddr,
    output logic [ADDRSIZE:0]   count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty
);

    localparam int PW    = int'(fifo_ptr_width(ADDRSIZE));
    localparam int DEPTH = int'(fifo_depth(ADDRSIZE));

    localparam logic [PW-1:0] AF_LVL = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AEMPTY_THRESH);
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push;
    logic          pop;

    // Handshakes only fire on the legal side; flush overrides both.
    assign push = wr_valid & wr_ready & ~flush;
    assign pop  = rd_valid & rd_ready & ~flush;

    fifo_ptr #(.PW(PW)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .en    (push),
        .flush (flush),
        .ptr   (wptr)
    );

    fifo_ptr #(.PW(PW)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .en    (pop),
        .flush (flush),
        .ptr   (rptr)
    );

    assign mem_wclken = push;
    assign mem_waddr  = wptr[ADDRSIZE-1:0];
    assign mem_raddr  = rptr[ADDRSIZE-1:0];

    // Status depends only on the registered pointers, never on this cycle's handshakes.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                   (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
    assign count = wptr - rptr;

    assign wr_ready     = ~full;
    assign rd_valid     = ~empty;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    // FULL_LVL is only a sanity anchor for the decode; count can never exceed it.
    logic unused_ok;
    assign unused_ok = (count <= FULL_LVL);

endmodule
